// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port synchronous RAM.
// Loads and fetches take one cycle after grant; partial stores do a read-modify-write.
// Optional build macro MEM_ARBITER_RR_EN: round-robin on simultaneous requests
// (default: fixed data-port priority).
module mem_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned RAM_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [WIDTH-1:0]  i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [WIDTH-1:0]  i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WIDTH/8-1:0] d_be,
  input  logic [WIDTH-1:0]  d_addr,
  input  logic [WIDTH-1:0]  d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WIDTH-1:0]  d_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_wren,
  output logic [WIDTH-1:0]  ram_wdata,
  input  logic [WIDTH-1:0]  ram_rdata
);

  localparam int unsigned NB = WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StRdWait, StRmw} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;  // 1 = data port owns the read in flight
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [NB-1:0]     be_q, be_d;
  logic [WIDTH-1:0]  i_rdata_q, d_rdata_q;
  logic [WIDTH-1:0]  merged;
  logic              pick_d;

  logic [RAM_AW-1:0] i_word, d_word;
  assign i_word = i_addr[RAM_AW+1:2];
  assign d_word = d_addr[RAM_AW+1:2];

  // Byte-offset and out-of-range address bits are intentionally dropped (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[WIDTH-1:RAM_AW+2], i_addr[1:0],
                              d_addr[WIDTH-1:RAM_AW+2], d_addr[1:0]};

`ifdef MEM_ARBITER_RR_EN
  logic last_q;  // 1 = data port was granted last

  // Data wins a tie only if instruction was granted last
  always_comb pick_d = d_req & (~i_req | ~last_q);

  // Remember which port took the most recent grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b0;
    end else if (d_gnt) begin
      last_q <= 1'b1;
    end else if (i_gnt) begin
      last_q <= 1'b0;
    end
  end
`else
  // Fixed priority: data port always wins
  always_comb pick_d = d_req;
`endif

  // Grants: combinational from requests in IDLE, suppressed while reset is held
  always_comb begin
    d_gnt = rst & (state_q == StIdle) & pick_d;
    i_gnt = rst & (state_q == StIdle) & i_req & ~pick_d;
  end

  // State and held-transaction registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      i_rdata_q <= i_rdata;
      d_rdata_q <= d_rdata;
    end
  end

  // Next-state: capture the granted request and choose the follow-up state
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    unique case (state_q)
      StIdle: begin
        if (d_gnt) begin
          owner_d = 1'b1;
          addr_d  = d_word;
          wdata_d = d_wdata;
          be_d    = d_be;
          if (!d_we) begin
            state_d = StRdWait;
          end else if (|d_be && !(&d_be)) begin
            state_d = StRmw;
          end
        end else if (i_gnt) begin
          owner_d = 1'b0;
          addr_d  = i_word;
          state_d = StRdWait;
        end
      end
      StRdWait: state_d = StIdle;
      StRmw:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Byte merge for read-modify-write: new bytes where enabled, old RAM bytes elsewhere
  always_comb begin
    merged = '0;
    for (int b = 0; b < NB; b++) begin
      merged[8*b +: 8] = be_q[b] ? wdata_q[8*b +: 8] : ram_rdata[8*b +: 8];
    end
  end

  // Outputs: RAM drive, response pulses, and held read data
  always_comb begin
    ram_addr  = addr_q;
    ram_wren  = 1'b0;
    ram_wdata = '0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (d_gnt && (!d_we || |d_be)) begin
          ram_addr = d_word;
          if (d_we && &d_be) begin
            ram_wren  = 1'b1;
            ram_wdata = d_wdata;
          end
        end else if (i_gnt) begin
          ram_addr = i_word;
        end
      end
      StRdWait: begin
        i_rvalid = ~owner_q;
        d_rvalid = owner_q;
      end
      StRmw: begin
        ram_wren  = 1'b1;
        ram_wdata = merged;
      end
      default: ;
    endcase
    i_rdata = i_rvalid ? ram_rdata : i_rdata_q;
    d_rdata = d_rvalid ? ram_rdata : d_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural synchronous RAM.
module tb_mem_arbiter;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned RAM_AW = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [WIDTH-1:0]  i_addr;
  logic              i_gnt, i_rvalid;
  logic [WIDTH-1:0]  i_rdata;
  logic              d_req, d_we;
  logic [3:0]        d_be;
  logic [WIDTH-1:0]  d_addr, d_wdata;
  logic              d_gnt, d_rvalid;
  logic [WIDTH-1:0]  d_rdata;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_wren;
  logic [WIDTH-1:0]  ram_wdata;
  logic [WIDTH-1:0]  ram_rdata;

  logic              bd_en;
  logic [RAM_AW-1:0] bd_addr;
  logic [WIDTH-1:0]  bd_data;
  logic [WIDTH-1:0]  mem [0:(1<<RAM_AW)-1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(WIDTH), .RAM_AW(RAM_AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_be     (d_be),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .ram_addr (ram_addr),
    .ram_wren (ram_wren),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Synchronous RAM: read data one cycle after address; backdoor preload port
  always @(posedge clk) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    else if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [RAM_AW-1:0] a, input logic [WIDTH-1:0] v);
    bd_en = 1'b1; bd_addr = a; bd_data = v;
    tick();
    bd_en = 1'b0;
  endtask

  // Grant code per cycle: 0 none, 1 instruction, 2 data
  function automatic logic [31:0] gcode();
    return d_gnt ? 32'd2 : (i_gnt ? 32'd1 : 32'd0);
  endfunction

  logic [31:0] exp_seq [6];

  initial begin
    rst = 1'b0; i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = '0;
    bd_en = 1'b0; bd_addr = '0; bd_data = '0;
    #1;
    bd_write(12'd4, 32'hDEADBEEF);
    bd_write(12'd0, 32'h55AA1234);
    @(negedge clk);
    check("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
    check("rst_ram_addr", {20'd0, ram_addr}, 32'd0);
    check("rst_ram_wren", {31'd0, ram_wren}, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    i_req = 1'b0;
    tick();
    rst = 1'b1;

    // Fetch from 0x10 -> word 4
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    check("fetch_gnt", {31'd0, i_gnt}, 32'd1);
    check("fetch_addr", {20'd0, ram_addr}, 32'd4);
    tick();
    i_req = 1'b0;
    @(negedge clk);
    check("fetch_rvalid", {31'd0, i_rvalid}, 32'd1);
    check("fetch_rdata", i_rdata, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    check("fetch_rvalid_drop", {31'd0, i_rvalid}, 32'd0);
    check("fetch_rdata_hold", i_rdata, 32'hDEADBEEF);

    // Full store to 0x8, then load back
    tick();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h8; d_wdata = 32'h12345678;
    @(negedge clk);
    check("st_gnt", {31'd0, d_gnt}, 32'd1);
    check("st_wren", {31'd0, ram_wren}, 32'd1);
    check("st_wdata", ram_wdata, 32'h12345678);
    check("st_addr", {20'd0, ram_addr}, 32'd2);
    tick();
    d_we = 1'b0;
    @(negedge clk);
    check("st_wren_one_cycle", {31'd0, ram_wren}, 32'd0);
    check("ld_gnt", {31'd0, d_gnt}, 32'd1);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    check("ld_rvalid", {31'd0, d_rvalid}, 32'd1);
    check("ld_rdata", d_rdata, 32'h12345678);
    tick();

    // Partial store: RMW into word 2
    bd_write(12'd2, 32'hAABBCCDD);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h2; d_addr = 32'h8; d_wdata = 32'h0000EE00;
    @(negedge clk);
    check("rmw_gnt", {31'd0, d_gnt}, 32'd1);
    check("rmw_no_wren_grant", {31'd0, ram_wren}, 32'd0);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    check("rmw_wren", {31'd0, ram_wren}, 32'd1);
    check("rmw_wdata", ram_wdata, 32'hAABBEEDD);
    check("rmw_addr", {20'd0, ram_addr}, 32'd2);
    tick();
    i_req = 1'b1; i_addr = 32'h8;
    @(negedge clk);
    check("rmw_idle_again", {31'd0, i_gnt}, 32'd1);
    check("rmw_wren_off", {31'd0, ram_wren}, 32'd0);
    tick();
    i_req = 1'b0;
    @(negedge clk);
    check("rmw_readback", i_rdata, 32'hAABBEEDD);
    tick();

    // Store with zero byte enables: granted, no access, no response
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h0; d_addr = 32'h8; d_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("be0_gnt", {31'd0, d_gnt}, 32'd1);
    check("be0_wren", {31'd0, ram_wren}, 32'd0);
    tick();
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check("be0_no_rvalid", {31'd0, d_rvalid}, 32'd0);
    tick();

    // Simultaneous requests held for 6 cycles
`ifdef MEM_ARBITER_RR_EN
    exp_seq = '{32'd2, 32'd0, 32'd1, 32'd0, 32'd2, 32'd0};
`else
    exp_seq = '{32'd2, 32'd0, 32'd2, 32'd0, 32'd2, 32'd0};
`endif
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("arb_cycle%0d", c), gcode(), exp_seq[c]);
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
    tick();

    // Reset while a fetch is in RD_WAIT
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    check("rstrd_gnt", {31'd0, i_gnt}, 32'd1);
    tick();
    i_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rstrd_no_rvalid", {31'd0, i_rvalid}, 32'd0);
    check("rstrd_i_rdata", i_rdata, 32'd0);
    check("rstrd_d_rdata", d_rdata, 32'd0);
    check("rstrd_ram_addr", {20'd0, ram_addr}, 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rstrd_no_late_rvalid", {31'd0, i_rvalid}, 32'd0);
    tick();
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    check("post_rst_gnt", {31'd0, i_gnt}, 32'd1);
    tick();
    i_req = 1'b0;
    @(negedge clk);
    check("post_rst_rvalid", {31'd0, i_rvalid}, 32'd1);
    check("post_rst_rdata", i_rdata, 32'hDEADBEEF);
    tick();

    // Address wrap: 0x4003 -> word 0
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4003;
    @(negedge clk);
    check("wrap_addr", {20'd0, ram_addr}, 32'd0);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    check("wrap_rdata", d_rdata, 32'h55AA1234);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001: Parameter WIDTH, default 32, data and byte-address width; SHALL be a multiple of 8 and at least 32.
- REQ-002: Parameter RAM_AW, default 12, RAM word-address width.
- REQ-003: clk  in  1  single clock; all state SHALL update on its rising edge.
- REQ-004: rst  in  1  reset; asynchronous assert, active-low.
- REQ-005: i_req  in  1  instruction-fetch read request; SHALL be held, with i_addr stable, until granted.
- REQ-006: i_addr  in  WIDTH  instruction byte address.
- REQ-007: i_gnt  out  1  instruction request accepted this cycle.
- REQ-008: i_rvalid  out  1  single-cycle pulse; i_rdata valid.
- REQ-009: i_rdata  out  WIDTH  fetched word.
- REQ-010: d_req  in  1  data request; SHALL be held, with all d_* inputs stable, until granted.
- REQ-011: d_we  in  1  0 = load, 1 = store.
- REQ-012: d_be  in  WIDTH/8  store byte enables; ignored for loads.
- REQ-013: d_addr  in  WIDTH  data byte address.
- REQ-014: d_wdata  in  WIDTH  store data, byte-lane aligned.
- REQ-015: d_gnt  out  1  data request accepted this cycle.
- REQ-016: d_rvalid  out  1  single-cycle pulse on load completion; d_rdata valid.
- REQ-017: d_rdata  out  WIDTH  loaded word.
- REQ-018: ram_addr  out  RAM_AW  RAM word address.
- REQ-019: ram_wren  out  1  RAM write enable.
- REQ-020: ram_wdata  out  WIDTH  RAM write data.
- REQ-021: ram_rdata  in  WIDTH  RAM read data; valid one cycle after ram_addr is presented.

Function
- REQ-022: FSM states: IDLE, RD_WAIT, RMW. i_gnt and d_gnt SHALL assert only in IDLE, and at most one of them per cycle.
- REQ-023: A transfer SHALL occur on any cycle where req and gnt are both high. gnt SHALL be combinational from req in IDLE.
- REQ-024: Word address = addr[RAM_AW+1:2]. Bits [1:0] and any upper bits SHALL be ignored, so addresses wrap modulo the RAM size.
- REQ-025: Read grant (i_req, or d_req with d_we=0) in cycle N: ram_addr SHALL be driven in cycle N and the FSM SHALL go to RD_WAIT.
- REQ-026: In RD_WAIT (cycle N+1): the owner's rvalid SHALL pulse with rdata = ram_rdata, then the FSM SHALL return to IDLE. Read latency is exactly 1 cycle after the grant.
- REQ-027: Full store (d_be all ones): ram_wren=1 with ram_wdata=d_wdata in the grant cycle; the FSM SHALL stay in IDLE; no rvalid.
- REQ-028: Partial store (d_be neither all ones nor zero): grant cycle reads the word, then the FSM goes to RMW.
- REQ-029: In RMW: ram_wren=1; each byte of ram_wdata SHALL come from d_wdata if its d_be bit is set, else from ram_rdata; address and data are held from the grant; then return to IDLE.
- REQ-030: Store with d_be=0: granted, no RAM access, no response.
- REQ-031: ram_wren SHALL be 0 in every cycle not named in REQ-027 or REQ-029.
- REQ-032: Arbitration on simultaneous requests: the data port SHALL win (fixed priority), unless REQ-038 applies.
- REQ-033: rdata outputs SHALL hold their last value between pulses.

Reset
- REQ-034: On rst low, the FSM SHALL go to IDLE immediately.
- REQ-035: On rst low, all outputs and the held address/data/be registers SHALL be 0.
- REQ-036: A read or RMW in flight at reset SHALL be abandoned: no rvalid and no RAM write afterwards.
- REQ-037: Grants SHALL be possible on the first rising edge after rst deasserts.

Configuration
- REQ-038: With MEM_ARBITER_RR_EN defined: a 1-bit last-grant register (reset: instruction) SHALL grant the port not granted last on simultaneous requests. Without it: fixed data priority and no register.

Verification
- REQ-039: Bench SHALL cover the following directed scenarios.
  - Fetch i_addr=0x10 with RAM word 4 = 0xDEADBEEF -> i_gnt in cycle N; i_rvalid=1 with i_rdata=0xDEADBEEF in N+1.
  - Store d_be=0xF, d_addr=0x8, d_wdata=0x12345678, then load 0x8 -> ram_wren for 1 cycle; d_rdata=0x12345678.
  - Word 2 = 0xAABBCCDD; store d_be=0x2, d_wdata=0x0000EE00 -> RMW write of 0xAABBEEDD, exactly 2 busy cycles.
  - i_req and d_req held high for 6 cycles -> fixed mode: all data grants first; RR_EN: grants alternate D, I, D, ...
  - rst low during RD_WAIT -> no rvalid; all outputs 0; a new fetch after reset completes normally.
  - Load d_addr=0x4003 with RAM_AW=12 -> ram_addr=0x000 (low bits dropped, upper bits wrapped).
